crc_stream: RTL

Framed, handshaked, multi-byte CRC generator/checker. It is the successor to the single-beat CRC calculator and generalises it to DATA_BYTES lanes per beat, a partial final beat, a valid/ready input, a result handshake and an expected-CRC compare. It sits between the packet deframer and the link status logic, and one instance serves each receive or transmit lane.

---
 rtl/crc_stream.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/crc_stream.sv
// crc_stream: framed, handshaked multi-lane CRC generator/checker.
// Folds up to DATA_BYTES bytes per accepted beat into the CRC register,
// presents the final CRC plus an expected-CRC compare on a result handshake.
module crc_stream #(
  parameter logic [63:0] POLY       = 64'h8005,
  parameter int unsigned CRC_SIZE   = 16,
  parameter int unsigned DATA_BYTES = 4,
  parameter logic [63:0] INIT       = 64'h0000,
  parameter bit          REF_IN     = 1'b1,
  parameter bit          REF_OUT    = 1'b1,
  parameter logic [63:0] XOR_OUT    = 64'hFFFF
) (
  input  logic                                clk_i,
  input  logic                                rst_n_i,
  input  logic                                soft_reset_i,
  input  logic                                s_valid_i,
  output logic                                s_ready_o,
  input  logic [8*DATA_BYTES-1:0]             s_data_i,
  input  logic                                s_last_i,
  input  logic [$clog2(DATA_BYTES+1)-1:0]     s_bytes_i,
  input  logic [CRC_SIZE-1:0]                 exp_crc_i,
  output logic                                res_valid_o,
  input  logic                                res_ready_i,
  output logic [CRC_SIZE-1:0]                 crc_o,
  output logic                                crc_ok_o,
  output logic                                busy_o
);

  function automatic logic [CRC_SIZE-1:0] bit_rev(input logic [CRC_SIZE-1:0] v);
    logic [CRC_SIZE-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < CRC_SIZE; i++) begin
      r[i] = v[CRC_SIZE-1-i];
    end
    return r;
  endfunction

  localparam logic [CRC_SIZE-1:0] POLY_N = POLY[CRC_SIZE-1:0];
  localparam logic [CRC_SIZE-1:0] POLY_R = bit_rev(POLY[CRC_SIZE-1:0]);
  localparam logic [CRC_SIZE-1:0] INIT_V = INIT[CRC_SIZE-1:0];
  localparam logic [CRC_SIZE-1:0] XOR_V  = XOR_OUT[CRC_SIZE-1:0];

  // One byte through the bit-serial LFSR, eight steps unrolled.
  function automatic logic [CRC_SIZE-1:0] fold_byte(input logic [CRC_SIZE-1:0] c,
                                                    input logic [7:0]          b);
    logic [CRC_SIZE-1:0] r;
    logic                fb;
    r = c;
    for (int unsigned k = 0; k < 8; k++) begin
      if (REF_IN) begin
        fb = r[0] ^ b[k];
        r  = r >> 1;
        if (fb) r = r ^ POLY_R;
      end else begin
        fb = r[CRC_SIZE-1] ^ b[7-k];
        r  = r << 1;
        if (fb) r = r ^ POLY_N;
      end
    end
    return r;
  endfunction

  // The register is only reversed when input and output reflection disagree.
  function automatic logic [CRC_SIZE-1:0] finalize(input logic [CRC_SIZE-1:0] r);
    logic [CRC_SIZE-1:0] t;
    t = (REF_OUT != REF_IN) ? bit_rev(r) : r;
    return t ^ XOR_V;
  endfunction

  typedef enum logic [1:0] {IDLE, ACCUM, RESULT} state_e;

  state_e              state_q, state_d;
  logic [CRC_SIZE-1:0] crc_q, crc_d;
  logic [CRC_SIZE-1:0] crc_out_q, crc_out_d;
  logic                crc_ok_q, crc_ok_d;
  logic                rdy_en_q;
  logic                accept;

  logic [CRC_SIZE-1:0] acc;
  logic [CRC_SIZE-1:0] crc_full;
  logic [CRC_SIZE-1:0] crc_part;
  logic [CRC_SIZE-1:0] crc_fin;
  int unsigned         n_lanes;

  // Lane chain: crc_full folds every lane, crc_part stops after n_lanes.
  always_comb begin
    n_lanes = DATA_BYTES;
    if (s_bytes_i != '0 && 32'(s_bytes_i) <= DATA_BYTES) n_lanes = 32'(s_bytes_i);
    acc      = crc_q;
    crc_part = crc_q;
    for (int unsigned i = 0; i < DATA_BYTES; i++) begin
      acc = fold_byte(acc, s_data_i[8*i +: 8]);
      if (i + 1 == n_lanes) crc_part = acc;
    end
    crc_full = acc;
    crc_fin  = finalize(crc_part);
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; soft reset overrides everything.
  always_comb begin
    state_d = state_q;
    if (soft_reset_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE, ACCUM: if (accept) state_d = s_last_i ? RESULT : ACCUM;
        RESULT:      if (res_ready_i) state_d = IDLE;
        default:     state_d = IDLE;
      endcase
    end
  end

  // Handshake and status outputs.
  always_comb begin
    s_ready_o   = rdy_en_q && (state_q != RESULT) && !soft_reset_i;
    res_valid_o = (state_q == RESULT);
    busy_o      = (state_q != IDLE);
    accept      = s_valid_i && s_ready_o;
    crc_o       = crc_out_q;
    crc_ok_o    = crc_ok_q;
  end

  // Datapath next values: register reloads INIT on abort or frame end.
  always_comb begin
    crc_d     = crc_q;
    crc_out_d = crc_out_q;
    crc_ok_d  = crc_ok_q;
    if (soft_reset_i) begin
      crc_d = INIT_V;
    end else if (accept) begin
      if (s_last_i) begin
        crc_d     = INIT_V;
        crc_out_d = crc_fin;
        crc_ok_d  = (crc_fin == exp_crc_i);
      end else begin
        crc_d = crc_full;
      end
    end
  end

  // Datapath registers; rdy_en_q keeps s_ready_o low while reset is held.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      crc_q     <= INIT_V;
      crc_out_q <= '0;
      crc_ok_q  <= 1'b0;
      rdy_en_q  <= 1'b0;
    end else begin
      crc_q     <= crc_d;
      crc_out_q <= crc_out_d;
      crc_ok_q  <= crc_ok_d;
      rdy_en_q  <= 1'b1;
    end
  end

endmodule
